// File: rtl/usb_rx_crc16_ctrl.sv
// usb_rx_crc16_ctrl: packet-level sequencer for the USB receive CRC16 checker.
// Walks SYNC -> PID -> payload -> EOP, gates the CRC16 shifter, withholds the
// two trailing CRC bytes from the payload stream and reports packet OK/error.
module usb_rx_crc16_ctrl #(
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_detected,
  input  logic             shift_enable,
  input  logic             byte_received,
  input  logic [7:0]       rcv_data,
  input  logic             eop,
  input  logic             crc_check_16,
  output logic             crc_clear,
  output logic             crc_enable,
  output logic [3:0]       rx_pid,
  output logic [7:0]       rx_data,
  output logic             rx_data_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic             packet_ok,
  output logic             packet_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  state_t           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [1:0]       held_q, held_d;
  logic [7:0]       h0_q, h0_d;
  logic [7:0]       h1_q, h1_d;
  logic [3:0]       rx_pid_q, rx_pid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             overflow;
  logic             pid_ok;

  assign pid_ok = (rcv_data[3:0] == ~rcv_data[7:4]);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= '0;
      held_q    <= '0;
      h0_q      <= '0;
      h1_q      <= '0;
      rx_pid_q  <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      held_q    <= held_d;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      rx_pid_q  <= rx_pid_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state and datapath update; in DATA a coincident byte is absorbed
  // into the hold buffer before the eop judgement looks at buffer/counter.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    held_d    = held_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
    rx_pid_d  = rx_pid_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    overflow  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_detected) begin
          state_d = S_PID;
          cnt_d   = '0;
          held_d  = '0;
        end
      end

      S_PID: begin
        if (start_detected) begin
          abort_d = 1'b1;
          state_d = S_PID;
          cnt_d   = '0;
          held_d  = '0;
        end else if (eop) begin
          state_d = S_ERR;
        end else if (byte_received) begin
          if (!pid_ok) begin
            state_d = S_ERR;
          end else begin
            rx_pid_d = rcv_data[3:0];
            if (rcv_data == PID_DATA0 || rcv_data == PID_DATA1) begin
              state_d  = S_DATA;
              bitcnt_d = '0;
              held_d   = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DATA: begin
        if (start_detected) begin
          abort_d = 1'b1;
          state_d = S_PID;
          cnt_d   = '0;
          held_d  = '0;
        end else begin
          if (shift_enable) begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
          if (byte_received) begin
            case (held_q)
              2'd0: begin
                h0_d   = rcv_data;
                held_d = 2'd1;
              end
              2'd1: begin
                h1_d   = rcv_data;
                held_d = 2'd2;
              end
              default: begin
                if (cnt_q >= CNT_W'(MAX_BYTES)) begin
                  overflow = 1'b1;
                end else begin
                  rx_data_d = h0_q;
                  valid_d   = 1'b1;
                  cnt_d     = cnt_q + CNT_W'(1);
                  h0_d      = h1_q;
                  h1_d      = rcv_data;
                end
              end
            endcase
          end
          if (overflow) begin
            state_d = S_ERR;
          end else if (eop) begin
            if (bitcnt_d != 3'd0 || held_d != 2'd2 || !crc_check_16) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE, S_ERR: begin
        if (start_detected) begin
          state_d = S_PID;
          cnt_d   = '0;
          held_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign crc_clear     = (state_q == S_IDLE) || start_detected;
  assign crc_enable    = (state_q == S_DATA);
  assign rx_pid        = rx_pid_q;
  assign rx_data       = rx_data_q;
  assign rx_data_valid = valid_q;
  assign byte_count    = cnt_q;
  assign packet_ok     = (state_q == S_DONE);
  assign packet_err    = (state_q == S_ERR) || abort_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_rx_crc16_ctrl.sv
// Self-checking bench for usb_rx_crc16_ctrl: directed vector table, hand
// sequences for abort/reset, and random packets against a packet-level model.
module tb_usb_rx_crc16_ctrl;
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_detected = 1'b0;
  logic       shift_enable = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       eop = 1'b0;
  logic       crc_check_16 = 1'b0;
  logic       crc_clear, crc_enable, rx_data_valid, packet_ok, packet_err, busy;
  logic [3:0] rx_pid;
  logic [7:0] rx_data;
  logic [6:0] byte_count;

  usb_rx_crc16_ctrl #(.MAX_BYTES(MAXB), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start_detected(start_detected),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .eop(eop), .crc_check_16(crc_check_16),
    .crc_clear(crc_clear), .crc_enable(crc_enable), .rx_pid(rx_pid),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .byte_count(byte_count),
    .packet_ok(packet_ok), .packet_err(packet_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: collects strobed bytes, pulses and enabled CRC shifts.
  logic [7:0] strb_q[$];
  int ok_cnt = 0, err_cnt = 0, en_cnt = 0;
  always @(negedge clk) begin
    if (rx_data_valid) strb_q.push_back(rx_data);
    if (packet_ok) ok_cnt++;
    if (packet_err) err_cnt++;
    if (crc_enable && shift_enable) en_cnt++;
  end

  int n_assert = 0, n_fail = 0;
  logic [7:0] pkt_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic se, input logic br,
                     input logic [7:0] d, input logic e, input logic c);
    start_detected = s; shift_enable = se; byte_received = br;
    rcv_data = d; eop = e; crc_check_16 = c;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e, input logic c);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, (i == 7), (i == 7) ? b : 8'h00, (i == 7) && e, (i == 7) && e && c);
  endtask

  task automatic send_body(input logic [7:0] pid, input int extra, input logic crc_ok,
                           input logic eop_last);
    send_byte(pid, 1'b0, 1'b0);
    for (int i = 0; i < pkt_q.size(); i++)
      send_byte(pkt_q[i], eop_last && (i == pkt_q.size() - 1), crc_ok);
    for (int i = 0; i < extra; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    if (!(eop_last && pkt_q.size() > 0)) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, crc_ok);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_pkt(input logic [7:0] pid, input int extra, input logic crc_ok,
                          input logic eop_last);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_body(pid, extra, crc_ok, eop_last);
  endtask

  // Packet-level reference: all wire bytes after the PID except the final two
  // are payload; payload beyond MAXB is an error at the first excess byte.
  task automatic model(input logic [7:0] pid, input int extra, input logic crc_ok,
                       output int eok, output int eerr, output int ens, output int ecnt,
                       output int een, inout logic [3:0] epid);
    int m;
    int emits;
    m = pkt_q.size();
    eok = 0; eerr = 0; ens = 0; ecnt = 0; een = 0;
    if (pid[3:0] != ~pid[7:4]) begin
      eerr = 1;
      return;
    end
    epid = pid[3:0];
    if (pid != 8'hC3 && pid != 8'h4B) begin
      eok = 1;
      return;
    end
    emits = (m >= 2) ? m - 2 : 0;
    if (emits > MAXB) begin
      ens = MAXB; ecnt = MAXB; eerr = 1; een = 8 * (MAXB + 3);
    end else begin
      ens = emits; ecnt = emits; een = 8 * m + extra;
      if (extra == 0 && m >= 2 && crc_ok) eok = 1; else eerr = 1;
    end
  endtask

  task automatic check_pkt(input string name, input int ok_b, input int err_b,
                           input int strb_b, input int en_b, input int eok, input int eerr,
                           input int ens, input int ecnt, input logic [3:0] epid,
                           input int een);
    int got;
    check({name, "/ok"}, ok_cnt - ok_b, eok);
    check({name, "/err"}, err_cnt - err_b, eerr);
    got = strb_q.size() - strb_b;
    check({name, "/nstrobe"}, got, ens);
    for (int i = 0; i < ens && i < got; i++)
      check({name, "/data"}, strb_q[strb_b + i], pkt_q[i]);
    check({name, "/rx_pid"}, rx_pid, epid);
    check({name, "/byte_count"}, byte_count, ecnt);
    check({name, "/crc_en_shifts"}, en_cnt - en_b, een);
    check({name, "/idle"}, busy, 0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  pid;
    int          n;
    logic [63:0] b;
    int          extra;
    logic        crc;
    logic        el;
    int          eok, eerr, ens, ecnt;
    logic [3:0]  epid;
    int          een;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int ok_b, err_b, strb_b, en_b;
    int eok, eerr, ens, ecnt, een;
    logic [3:0] pid_model;
    logic [7:0] pid;
    int extra, len;
    logic crc, el;

    tbl[0]  = '{"data0_ok",      8'hC3, 5, 64'h000000B2A1030201, 0, 1'b1, 1'b0, 1, 0, 3, 3, 4'h3, 40};
    tbl[1]  = '{"data0_crcbad",  8'hC3, 5, 64'h000000B2A1030201, 0, 1'b0, 1'b0, 0, 1, 3, 3, 4'h3, 40};
    tbl[2]  = '{"ack",           8'hD2, 0, 64'h0,                0, 1'b1, 1'b0, 1, 0, 0, 0, 4'h2, 0};
    tbl[3]  = '{"bad_pid",       8'hC7, 0, 64'h0,                0, 1'b1, 1'b0, 0, 1, 0, 0, 4'h2, 0};
    tbl[4]  = '{"align",         8'hC3, 2, 64'h2211,             5, 1'b1, 1'b0, 0, 1, 0, 0, 4'h3, 21};
    tbl[5]  = '{"too_long",      8'hC3, 7, 64'h00E2E15040302010, 0, 1'b1, 1'b0, 0, 1, 4, 4, 4'h3, 56};
    tbl[6]  = '{"data1_eop_last",8'h4B, 4, 64'h0A090807,         0, 1'b1, 1'b1, 1, 0, 2, 2, 4'hB, 32};
    tbl[7]  = '{"one_byte",      8'hC3, 1, 64'h5A,               0, 1'b1, 1'b0, 0, 1, 0, 0, 4'h3, 8};
    tbl[8]  = '{"max_exact",     8'h4B, 6, 64'hC2C104030201,     0, 1'b1, 1'b0, 1, 0, 4, 4, 4'hB, 48};
    tbl[9]  = '{"crc_only",      8'hC3, 2, 64'hFFEE,             0, 1'b1, 1'b0, 1, 0, 0, 0, 4'h3, 16};
    tbl[10] = '{"empty",         8'hC3, 0, 64'h0,                0, 1'b1, 1'b0, 0, 1, 0, 0, 4'h3, 0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst/crc_clear", crc_clear, 1);
    check("rst/crc_enable", crc_enable, 0);
    check("rst/rx_pid", rx_pid, 0);
    check("rst/rx_data", rx_data, 0);
    check("rst/valid", rx_data_valid, 0);
    check("rst/byte_count", byte_count, 0);
    check("rst/ok", packet_ok, 0);
    check("rst/err", packet_err, 0);
    check("rst/busy", busy, 0);
    rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Directed vector table
    for (int t = 0; t < 11; t++) begin
      pkt_q.delete();
      for (int i = 0; i < tbl[t].n; i++) pkt_q.push_back(tbl[t].b[8*i +: 8]);
      ok_b = ok_cnt; err_b = err_cnt; strb_b = strb_q.size(); en_b = en_cnt;
      send_pkt(tbl[t].pid, tbl[t].extra, tbl[t].crc, tbl[t].el);
      check_pkt(tbl[t].name, ok_b, err_b, strb_b, en_b, tbl[t].eok, tbl[t].eerr,
                tbl[t].ens, tbl[t].ecnt, tbl[t].epid, tbl[t].een);
    end

    // Abort by a new SYNC in DATA, then a clean packet
    ok_b = ok_cnt; err_b = err_cnt; strb_b = strb_q.size();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("abort/clear_low_in_data", crc_clear, 0);
    check("abort/enable_in_data", crc_enable, 1);
    check("abort/busy", busy, 1);
    check("abort/count_mid", byte_count, 1);
    start_detected = 1'b1;
    #1;
    check("abort/clear_on_start", crc_clear, 1);
    @(posedge clk); #1;
    check("abort/err_pulse", packet_err, 1);
    check("abort/count_cleared", byte_count, 0);
    pkt_q.delete();
    pkt_q.push_back(8'h01); pkt_q.push_back(8'h02);
    pkt_q.push_back(8'hE0); pkt_q.push_back(8'hE1);
    send_body(8'hC3, 0, 1'b1, 1'b0);
    check("abort/ok", ok_cnt - ok_b, 1);
    check("abort/err", err_cnt - err_b, 1);
    check("abort/nstrobe", strb_q.size() - strb_b, 3);
    if (strb_q.size() - strb_b == 3) begin
      check("abort/d0", strb_q[strb_b], 8'hAA);
      check("abort/d1", strb_q[strb_b + 1], 8'h01);
      check("abort/d2", strb_q[strb_b + 2], 8'h02);
    end
    check("abort/byte_count", byte_count, 2);

    // Random packets against the model
    pid_model = 4'h3;
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: pid = 8'hC3;
        3, 4, 5: pid = 8'h4B;
        6: pid = 8'hD2;
        7: pid = 8'h5A;
        default: pid = 8'($urandom_range(0, 255));
      endcase
      len = $urandom_range(0, 8);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      extra = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      crc = ($urandom_range(0, 3) != 0);
      el = (extra == 0 && len > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      model(pid, extra, crc, eok, eerr, ens, ecnt, een, pid_model);
      ok_b = ok_cnt; err_b = err_cnt; strb_b = strb_q.size(); en_b = en_cnt;
      send_pkt(pid, extra, crc, el);
      check_pkt($sformatf("rand%0d", r), ok_b, err_b, strb_b, en_b, eok, eerr, ens, ecnt,
                pid_model, een);
    end

    // Reset in the middle of DATA
    ok_b = ok_cnt; err_b = err_cnt;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte(8'h4B, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    rst = 1'b1;
    start_detected = 1'b0; shift_enable = 1'b0; byte_received = 1'b0;
    rcv_data = 8'h00; eop = 1'b0; crc_check_16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst/crc_clear", crc_clear, 1);
    check("midrst/crc_enable", crc_enable, 0);
    check("midrst/rx_pid", rx_pid, 0);
    check("midrst/rx_data", rx_data, 0);
    check("midrst/valid", rx_data_valid, 0);
    check("midrst/byte_count", byte_count, 0);
    check("midrst/busy", busy, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("midrst/no_ok", ok_cnt - ok_b, 0);
    check("midrst/no_err", err_cnt - err_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
